// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: one grant at a time, held while the owner keeps requesting.
// Optional hold-timeout preemption is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_n #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [GW-1:0]   gnt_id,
  output logic            gnt_vld,
  output logic            preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic            preempt_q, preempt_d;
  logic            new_grant;
  logic            timeout;

  if (NREQ < 2 || NREQ > 32) begin : g_bad_nreq
    $error("rr_arbiter_n: NREQ must be in 2..32");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter_n: MAX_HOLD must be at least 2");
  end

  // Masking the current grant covers every case: idle (gnt=0), owner drop
  // (owner bit already 0) and timeout (owner must be excluded).
  logic [NREQ-1:0] cand;
  logic            any_cand;
  logic            owner_req;

  assign cand      = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  logic [GW-1:0]   start_idx;
  logic [NREQ-1:0] rot;

  assign start_idx = (ptr_q == GW'(NREQ - 1)) ? '0 : ptr_q + GW'(1);
  assign rot       = (cand >> start_idx) | (cand << (NREQ - int'(start_idx)));

  logic [NREQ:0]          below;
  logic [NREQ-1:0]        hit;
  logic [NREQ:0][GW-1:0]  off_chain;
  logic [NREQ-1:0]        win_oh;

  assign below[0]     = 1'b0;
  assign off_chain[0] = '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_prio
    assign hit[gi]           = rot[gi] & ~below[gi];
    assign below[gi+1]       = below[gi] | rot[gi];
    assign off_chain[gi+1]   = off_chain[gi] | (hit[gi] ? GW'(gi) : '0);
  end

  assign any_cand = below[NREQ];

  // Winner is the rotated offset added back to the search start, modulo NREQ.
  logic [GW:0]   win_sum;
  logic [GW-1:0] win_idx;

  assign win_sum = {1'b0, start_idx} + {1'b0, off_chain[NREQ]};
  assign win_idx = (win_sum >= (GW + 1)'(NREQ)) ? GW'(win_sum - (GW + 1)'(NREQ))
                                                : win_sum[GW-1:0];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign win_oh[gi] = (win_idx == GW'(gi));
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hcnt_q, hcnt_d;

  assign timeout = (hcnt_q == HW'(MAX_HOLD - 1)) && any_cand;

  always_comb begin
    hcnt_d = hcnt_q;
    if (new_grant) begin
      hcnt_d = '0;
    end else if (state_q == OWNED && hcnt_q != HW'(MAX_HOLD - 1)) begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    preempt_d = 1'b0;
    new_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_cand) begin
          new_grant = 1'b1;
        end
      end
      OWNED: begin
        // An owner drop wins over a coincident timeout, so no preempt then.
        if (!owner_req) begin
          if (any_cand) begin
            new_grant = 1'b1;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
          end
        end else if (timeout) begin
          new_grant = 1'b1;
          preempt_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (new_grant) begin
      state_d  = OWNED;
      ptr_d    = win_idx;
      gnt_d    = win_oh;
      gnt_id_d = win_idx;
    end
  end

  assign vld_d = |gnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= GW'(NREQ - 1);
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      vld_q     <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      vld_q     <= vld_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = vld_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n (NREQ=4, MAX_HOLD=4): vector table, corner sequences,
// and randomized traffic against a queue-free ownership model.
module tb_rr_arbiter_n;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       preempt;

  always #5 clk = ~clk;

  rr_arbiter_n #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference: who owns the bus, who won last, how many cycles grant has been visible.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_held  = 0;
  bit m_pre   = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] rq;
    logic [3:0] eg;
    logic [1:0] eid;
    logic       evld;
  } vec_t;

  vec_t tbl[$];

  function automatic int pick(input logic [3:0] c, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (last + k) % NREQ;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rr);
    int w;
    if (rr) begin
      m_owner = -1; m_last = NREQ - 1; m_held = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (m_owner < 0 || !r[m_owner]) begin
        w = pick(r, m_last);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
`ifdef ARB_TIMEOUT_EN
        logic [3:0] others;
        others = r & ~(4'b0001 << m_owner);
        if (m_held >= MAX_HOLD && others != 4'b0000) begin
          w = pick(others, m_last);
          m_owner = w; m_last = w; m_held = 1; m_pre = 1'b1;
        end else begin
          m_held++;
        end
`else
        m_held++;
`endif
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic tick(input logic [3:0] r, input logic rr);
    req   = r;
    reset = rr;
    @(posedge clk);
    model_step(r, rr);
    @(negedge clk);
  endtask

  task automatic expect_gp(input string name, input logic [3:0] eg, input logic ep);
    $display("%s: req=%b gnt=%b id=%0d vld=%b pre=%b", name, req, gnt, gnt_id, gnt_vld, preempt);
    check({name, "_gnt"}, gnt, eg);
    check({name, "_pre"}, preempt, ep);
  endtask

  task automatic check_model(input int cyc);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0000;
    $display("rnd %0d: rst=%b req=%b gnt=%b id=%0d pre=%b", cyc, reset, req, gnt, gnt_id, preempt);
    check("rnd_gnt", gnt, eg);
    check("rnd_vld", gnt_vld, m_owner >= 0);
    check("rnd_pre", preempt, m_pre);
    if (m_owner >= 0) check("rnd_id", gnt_id, m_owner);
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;

    tbl.push_back('{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0});

    foreach (tbl[i]) begin
      tick(tbl[i].rq, tbl[i].rst);
      $display("vec %0d: rst=%b req=%b gnt=%b id=%0d vld=%b pre=%b",
               i, tbl[i].rst, tbl[i].rq, gnt, gnt_id, gnt_vld, preempt);
      check("vec_gnt", gnt, tbl[i].eg);
      check("vec_vld", gnt_vld, tbl[i].evld);
      check("vec_pre", preempt, 1'b0);
      if (tbl[i].evld || tbl[i].rst) check("vec_id", gnt_id, tbl[i].eid);
    end

    // Long single-master hold never preempts.
    for (int i = 0; i < 30; i++) begin
      tick(4'b0100, 1'b0);
      expect_gp("hold30", 4'b0100, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin tick(4'b0011, 1'b0); expect_gp("to_own0", 4'b0001, 1'b0); end
    tick(4'b0011, 1'b0); expect_gp("to_pre1", 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) begin tick(4'b0011, 1'b0); expect_gp("to_own1", 4'b0010, 1'b0); end
    tick(4'b0011, 1'b0); expect_gp("to_pre0", 4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin tick(4'b0011, 1'b0); expect_gp("to_own0b", 4'b0001, 1'b0); end
    // Owner drops in its timeout cycle: plain handover.
    tick(4'b0010, 1'b0); expect_gp("drop_vs_to", 4'b0010, 1'b0);
    // Saturated counter with nobody waiting, then a rival appears.
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin tick(4'b0001, 1'b0); expect_gp("sat", 4'b0001, 1'b0); end
    tick(4'b0011, 1'b0); expect_gp("sat_pre", 4'b0010, 1'b1);
`else
    tick(4'b0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(4'b0011, 1'b0);
      expect_gp("no_to", 4'b0001, 1'b0);
    end
`endif

    begin
      logic [3:0] rq;
      logic       rr;
      rq = 4'b0000;
      tick(4'b0000, 1'b1);
      for (int c = 0; c < 600; c++) begin
        rr = ($urandom_range(63) == 0);
        if ($urandom_range(9) < 3) rq = 4'($urandom);
        tick(rq, rr);
        check_model(c);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin bus arbiter for the crossbar. It grants exactly one of `NREQ` masters at a time. A master keeps the grant while it holds its request, and the arbiter hands over to the next master without an idle cycle when that request drops. An optional hold-timeout (build-time macro) preempts a master that holds the bus too long while others wait.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 16: maximum grant length in cycles while other masters wait; legal range ≥2. Used only with `ARB_TIMEOUT_EN`.
- `GW`, localparam = `$clog2(NREQ)`: width of the encoded grant.

Ports:
- `clk`, in, 1: single clock; every register updates on its rising edge.
- `reset`, in, 1: synchronous reset, active-high.
- `req`, in, `NREQ`: request per master; bit i belongs to master i.
- `gnt`, out, `NREQ`: registered grant, one-hot or all-zero.
- `gnt_id`, out, `GW`: encoded index of the granted master. Valid only while `gnt_vld` = 1.
- `gnt_vld`, out, 1: registered; equals `|gnt`.
- `preempt`, out, 1: registered one-cycle pulse marking a timeout handover. Tied to 0 without the macro.

## Operation
- State: `IDLE` (no grant) or `OWNED` (one grant held). Pointer `ptr` [GW-1:0] holds the index of the last winner.
- Winner selection: the first set bit of the candidate vector, searching from index `ptr+1` upward and wrapping modulo `NREQ`.
- `IDLE`:
  - If `req` is nonzero, the candidate vector is `req`. At the next edge, `gnt` = one-hot(winner), `ptr` = winner, and the state moves to `OWNED`.
  - If `req` is zero, the arbiter stays in `IDLE`.
- `OWNED`, owner index o:
  - `req[o]` = 1 and no timeout: hold. `gnt`, `gnt_id` and `ptr` are unchanged.
  - `req[o]` = 0: re-arbitrate in the same cycle. The candidate vector is `req` (owner already excluded because its bit is 0).
    - If any candidate exists, the next edge grants the new winner directly, with no idle cycle between grants.
    - Otherwise the next edge moves to `IDLE` with `gnt` = 0.
  - Timeout (macro only): the candidate vector is `req & ~gnt`. The next edge grants the winner, updates `ptr`, and sets `preempt` = 1 for that one cycle.
- Simultaneous events:
  - Owner drop and timeout in the same cycle: treated as a drop; `preempt` stays 0.
  - A new request arriving in the same cycle as the owner drops takes part in that arbitration.
- Reset outputs: `gnt` = 0, `gnt_id` = 0, `gnt_vld` = 0, `preempt` = 0.
- Reset state: `ptr` = `NREQ-1`, so master 0 has highest priority first; hold counter = 0; state `IDLE`.
- Reset asserted during `OWNED` clears everything at that edge, regardless of `req`.

## Timing
- Latency from `req` rising to `gnt` is 1 cycle. A request asserted in cycle n produces a grant visible in cycle n+1.
- Handover after the owner drops its request is 1 cycle. The new `gnt` appears in the cycle after the owner's last deasserted-request cycle.
- Masters must sample `gnt` and must not assume a grant before it is visible.
- Hold counter `hcnt` (width `$clog2(MAX_HOLD)`):
  - Loads 0 at every edge that issues a new grant.
  - Increments by 1 each held cycle and saturates at `MAX_HOLD-1`.
- Timeout condition: `hcnt` == `MAX_HOLD-1` AND `(req & ~gnt)` is nonzero.
- A master that holds its request while others wait therefore owns the bus for exactly `MAX_HOLD` cycles.
- If nobody else waits, the counter sits at saturation. Preemption then fires on the edge following the first cycle another request is seen.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter and timeout preemption are built in.
  - `preempt` is driven as described above.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `MAX_HOLD` is ignored.
  - An owner keeps the grant indefinitely while its request is high.
  - `preempt` is constant 0.

## Test plan
All scenarios use `NREQ`=4, `MAX_HOLD`=4.
1. Reset, then `req`=0000 for 3 cycles → `gnt`=0000, `gnt_vld`=0. Then `req`=1111 → next cycle `gnt`=0001, `gnt_id`=0.
2. `req`=1111 held; each owner drops its own bit for one cycle after its grant → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with no zero cycle between grants.
3. `req`=0100 held for 30 cycles → `gnt`=0100 throughout; `preempt`=0 even with the macro defined.
4. Macro defined, `req`=0011 from `IDLE` → `gnt`=0001 for 4 cycles, then 0010 with `preempt`=1 for one cycle, then 0001 again after 4 more cycles.
5. Reset pulsed for one cycle while `gnt`=0100 → next cycle `gnt`=0000, `gnt_vld`=0. A following `req`=1111 grants 0001.
6. Macro undefined, `req`=0011 held for 20 cycles → `gnt`=0001 throughout; `preempt`=0.
